// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage
//  Description : Instruction-decode stage of the 16-bit pipelined processor.
//                Holds the IF/ID register, decodes the held instruction,
//                drives register-file read addresses, detects load-use
//                hazards (one-cycle stall plus bubble) and honours branch
//                flushes from EX. Loads the ID/EX pipeline register.
//                Optional feature macro: HALT_DECODE_EN (sticky HALT on op 15).
//  Revision    : 1.0 - initial release
// ============================================================================
module id_stage #(
    parameter int DSIZE = 16,
    parameter int ASIZE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [DSIZE-1:0] if_instr,
    input  logic [DSIZE-1:0] if_pc,
    output logic             if_ready,
    input  logic             flush,
    output logic [ASIZE-1:0] raddr1,
    output logic [ASIZE-1:0] raddr2,
    input  logic [DSIZE-1:0] rdata1,
    input  logic [DSIZE-1:0] rdata2,
    output logic             ex_valid,
    output logic [DSIZE-1:0] ex_pc,
    output logic [3:0]       ex_aluop,
    output logic [DSIZE-1:0] ex_op1,
    output logic [DSIZE-1:0] ex_op2,
    output logic [DSIZE-1:0] ex_sdata,
    output logic [ASIZE-1:0] ex_waddr,
    output logic             ex_wen,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic             halted
);

    // ------------------------------------------------------------------
    // Opcode encodings (instr[15:12])
    // ------------------------------------------------------------------
    localparam logic [3:0] c_OP_OR   = 4'd3;   // 0..3 : register ALU ops
    localparam logic [3:0] c_OP_SHLO = 4'd4;   // 4..7 : shifts with imm4
    localparam logic [3:0] c_OP_SHHI = 4'd7;
    localparam logic [3:0] c_OP_LW   = 4'd8;
    localparam logic [3:0] c_OP_SW   = 4'd9;
    localparam logic [3:0] c_OP_LHB  = 4'd10;
    localparam logic [3:0] c_OP_LLB  = 4'd11;
`ifdef HALT_DECODE_EN
    localparam logic [3:0] c_OP_HALT = 4'd15;
`endif

    // ------------------------------------------------------------------
    // IF/ID register
    // ------------------------------------------------------------------
    logic             id_valid_q, id_valid_d;
    logic [DSIZE-1:0] id_instr_q, id_instr_d;
    logic [DSIZE-1:0] id_pc_q,    id_pc_d;

    // ------------------------------------------------------------------
    // ID/EX register
    // ------------------------------------------------------------------
    logic             ex_valid_q,    ex_valid_d;
    logic [DSIZE-1:0] ex_pc_q,       ex_pc_d;
    logic [3:0]       ex_aluop_q,    ex_aluop_d;
    logic [DSIZE-1:0] ex_op1_q,      ex_op1_d;
    logic [DSIZE-1:0] ex_op2_q,      ex_op2_d;
    logic [DSIZE-1:0] ex_sdata_q,    ex_sdata_d;
    logic [ASIZE-1:0] ex_waddr_q,    ex_waddr_d;
    logic             ex_wen_q,      ex_wen_d;
    logic             ex_memread_q,  ex_memread_d;
    logic             ex_memwrite_q, ex_memwrite_d;

    // ------------------------------------------------------------------
    // Decode results for the instruction held in IF/ID
    // ------------------------------------------------------------------
    logic [3:0]       w_op;
    logic [ASIZE-1:0] w_rd, w_rs, w_rt;
    logic [DSIZE-1:0] w_imm4_sext, w_imm4_zext, w_imm8_sext, w_imm8_zext;

    logic [ASIZE-1:0] dec_raddr1, dec_raddr2;
    logic             dec_use1, dec_use2;
    logic [3:0]       dec_aluop;
    logic [DSIZE-1:0] dec_op1, dec_op2, dec_sdata;
    logic [ASIZE-1:0] dec_waddr;
    logic             dec_wen, dec_memread, dec_memwrite;
`ifdef HALT_DECODE_EN
    logic             dec_halt;
`endif

    logic             w_stall;
    logic             w_halted;       // stage is frozen by a decoded HALT
    logic             w_issue_block;  // suppress issue of the held instruction

    // Field extraction: op=[15:12], rd=[11:8], rs=[7:4], rt=[3:0]
    assign w_op = id_instr_q[15:12];
    assign w_rd = id_instr_q[11:8];
    assign w_rs = id_instr_q[7:4];
    assign w_rt = id_instr_q[3:0];

    assign w_imm4_sext = {{(DSIZE-4){id_instr_q[3]}}, id_instr_q[3:0]};
    assign w_imm4_zext = {{(DSIZE-4){1'b0}},          id_instr_q[3:0]};
    assign w_imm8_sext = {{(DSIZE-8){id_instr_q[7]}}, id_instr_q[7:0]};
    assign w_imm8_zext = {{(DSIZE-8){1'b0}},          id_instr_q[7:0]};

    // Decode the held instruction into read addresses, operands and controls.
    // Anything not listed (reserved ops) falls through as an all-zero bubble.
    always_comb begin
        dec_raddr1   = '0;
        dec_raddr2   = '0;
        dec_use1     = 1'b0;
        dec_use2     = 1'b0;
        dec_aluop    = 4'd0;
        dec_op1      = '0;
        dec_op2      = '0;
        dec_sdata    = '0;
        dec_waddr    = '0;
        dec_wen      = 1'b0;
        dec_memread  = 1'b0;
        dec_memwrite = 1'b0;
`ifdef HALT_DECODE_EN
        dec_halt     = 1'b0;
`endif
        if (w_op <= c_OP_OR) begin
            // ADD/SUB/AND/OR: rd = rs op rt
            dec_raddr1 = w_rs;
            dec_raddr2 = w_rt;
            dec_use1   = 1'b1;
            dec_use2   = 1'b1;
            dec_aluop  = w_op;
            dec_op1    = rdata1;
            dec_op2    = rdata2;
            dec_wen    = 1'b1;
            dec_waddr  = w_rd;
        end else if (w_op >= c_OP_SHLO && w_op <= c_OP_SHHI) begin
            // Shifts: rd = rs shifted by unsigned imm4
            dec_raddr1 = w_rs;
            dec_use1   = 1'b1;
            dec_aluop  = w_op;
            dec_op1    = rdata1;
            dec_op2    = w_imm4_zext;
            dec_wen    = 1'b1;
            dec_waddr  = w_rd;
        end else if (w_op == c_OP_LW) begin
            // LW: address = rs + signed imm4
            dec_raddr1  = w_rs;
            dec_use1    = 1'b1;
            dec_aluop   = w_op;
            dec_op1     = rdata1;
            dec_op2     = w_imm4_sext;
            dec_memread = 1'b1;
            dec_wen     = 1'b1;
            dec_waddr   = w_rd;
        end else if (w_op == c_OP_SW) begin
            // SW: address = rs + signed imm4, data comes from rd
            dec_raddr1   = w_rs;
            dec_raddr2   = w_rd;
            dec_use1     = 1'b1;
            dec_use2     = 1'b1;
            dec_aluop    = w_op;
            dec_op1      = rdata1;
            dec_op2      = w_imm4_sext;
            dec_sdata    = rdata2;
            dec_memwrite = 1'b1;
        end else if (w_op == c_OP_LHB) begin
            // LHB: rd is both source and destination
            dec_raddr1 = w_rd;
            dec_use1   = 1'b1;
            dec_aluop  = w_op;
            dec_op1    = rdata1;
            dec_op2    = w_imm8_zext;
            dec_wen    = 1'b1;
            dec_waddr  = w_rd;
        end else if (w_op == c_OP_LLB) begin
            // LLB: no register sources, so it can never load-use stall
            dec_aluop = w_op;
            dec_op2   = w_imm8_sext;
            dec_wen   = 1'b1;
            dec_waddr = w_rd;
        end
`ifdef HALT_DECODE_EN
        else if (w_op == c_OP_HALT) begin
            dec_halt = 1'b1;
        end
`endif
    end

    assign raddr1 = dec_raddr1;
    assign raddr2 = dec_raddr2;

    // Load-use hazard: the instruction in EX is a load whose destination is
    // a source actually consumed by the instruction in ID.
    assign w_stall = id_valid_q & ex_valid_q & ex_memread_q &
                     ((dec_use1 & (dec_raddr1 == ex_waddr_q)) |
                      (dec_use2 & (dec_raddr2 == ex_waddr_q)));

`ifdef HALT_DECODE_EN
    logic halted_q, halted_d;

    // HALT becomes sticky only when it would otherwise have issued normally
    always_comb begin
        halted_d = halted_q;
        if (!flush && !w_stall && id_valid_q && dec_halt) begin
            halted_d = 1'b1;
        end
    end

    // Sticky halt flag; only reset clears it
    always_ff @(posedge clk) begin
        if (rst) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign w_halted      = halted_q;
    assign w_issue_block = halted_q | dec_halt;
`else
    assign w_halted      = 1'b0;
    assign w_issue_block = 1'b0;
`endif

    assign halted   = w_halted;
    assign if_ready = ~w_stall & ~w_halted;

    // IF/ID next state: flush empties the slot, otherwise load when accepted
    always_comb begin
        id_valid_d = id_valid_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        if (flush) begin
            id_valid_d = 1'b0;
            id_instr_d = '0;
            id_pc_d    = '0;
        end else if (if_ready) begin
            id_valid_d = if_valid;
            id_instr_d = if_instr;
            id_pc_d    = if_pc;
        end
    end

    // ID/EX next state: bubble by default, decoded values on a normal issue
    always_comb begin
        ex_valid_d    = 1'b0;
        ex_pc_d       = '0;
        ex_aluop_d    = 4'd0;
        ex_op1_d      = '0;
        ex_op2_d      = '0;
        ex_sdata_d    = '0;
        ex_waddr_d    = '0;
        ex_wen_d      = 1'b0;
        ex_memread_d  = 1'b0;
        ex_memwrite_d = 1'b0;
        if (!flush && !w_stall && id_valid_q && !w_issue_block) begin
            ex_valid_d    = 1'b1;
            ex_pc_d       = id_pc_q;
            ex_aluop_d    = dec_aluop;
            ex_op1_d      = dec_op1;
            ex_op2_d      = dec_op2;
            ex_sdata_d    = dec_sdata;
            ex_waddr_d    = dec_waddr;
            ex_wen_d      = dec_wen;
            ex_memread_d  = dec_memread;
            ex_memwrite_d = dec_memwrite;
        end
    end

    // Pipeline registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid_q    <= 1'b0;
            id_instr_q    <= '0;
            id_pc_q       <= '0;
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_aluop_q    <= 4'd0;
            ex_op1_q      <= '0;
            ex_op2_q      <= '0;
            ex_sdata_q    <= '0;
            ex_waddr_q    <= '0;
            ex_wen_q      <= 1'b0;
            ex_memread_q  <= 1'b0;
            ex_memwrite_q <= 1'b0;
        end else begin
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            ex_valid_q    <= ex_valid_d;
            ex_pc_q       <= ex_pc_d;
            ex_aluop_q    <= ex_aluop_d;
            ex_op1_q      <= ex_op1_d;
            ex_op2_q      <= ex_op2_d;
            ex_sdata_q    <= ex_sdata_d;
            ex_waddr_q    <= ex_waddr_d;
            ex_wen_q      <= ex_wen_d;
            ex_memread_q  <= ex_memread_d;
            ex_memwrite_q <= ex_memwrite_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_pc       = ex_pc_q;
    assign ex_aluop    = ex_aluop_q;
    assign ex_op1      = ex_op1_q;
    assign ex_op2      = ex_op2_q;
    assign ex_sdata    = ex_sdata_q;
    assign ex_waddr    = ex_waddr_q;
    assign ex_wen      = ex_wen_q;
    assign ex_memread  = ex_memread_q;
    assign ex_memwrite = ex_memwrite_q;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_stage
//  Description : Directed self-checking bench for id_stage. A small register
//                file array answers the read addresses combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_stage;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        if_ready;
    logic        flush;
    logic [3:0]  raddr1, raddr2;
    logic [15:0] rdata1, rdata2;
    logic        ex_valid;
    logic [15:0] ex_pc;
    logic [3:0]  ex_aluop;
    logic [15:0] ex_op1, ex_op2, ex_sdata;
    logic [3:0]  ex_waddr;
    logic        ex_wen, ex_memread, ex_memwrite;
    logic        halted;

    logic [15:0] rf [0:15];
    int          tests;
    int          fails;

    assign rdata1 = rf[raddr1];
    assign rdata2 = rf[raddr2];

    id_stage #(.DSIZE(16), .ASIZE(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_ready   (if_ready),
        .flush      (flush),
        .raddr1     (raddr1),
        .raddr2     (raddr2),
        .rdata1     (rdata1),
        .rdata2     (rdata2),
        .ex_valid   (ex_valid),
        .ex_pc      (ex_pc),
        .ex_aluop   (ex_aluop),
        .ex_op1     (ex_op1),
        .ex_op2     (ex_op2),
        .ex_sdata   (ex_sdata),
        .ex_waddr   (ex_waddr),
        .ex_wen     (ex_wen),
        .ex_memread (ex_memread),
        .ex_memwrite(ex_memwrite),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run can never hang
    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one instruction for exactly one edge, then withdraw the offer
    task automatic offer(input logic [15:0] ins, input logic [15:0] pc);
        if_valid = 1'b1;
        if_instr = ins;
        if_pc    = pc;
        step();
        if_valid = 1'b0;
        if_instr = 16'h0000;
        if_pc    = 16'h0000;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        for (int i = 0; i < 16; i++) rf[i] = 16'h0000;
        rf[1] = 16'h0005;
        rf[2] = 16'h0001;
        rf[4] = 16'h0040;
        rf[7] = 16'h1234;

        rst      = 1'b1;
        flush    = 1'b0;
        if_valid = 1'b0;
        if_instr = 16'h0000;
        if_pc    = 16'h0000;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_ex_valid",    ex_valid,    16'h0);
        chk("rst_ex_pc",       ex_pc,       16'h0);
        chk("rst_ex_aluop",    ex_aluop,    16'h0);
        chk("rst_ex_op1",      ex_op1,      16'h0);
        chk("rst_ex_op2",      ex_op2,      16'h0);
        chk("rst_ex_sdata",    ex_sdata,    16'h0);
        chk("rst_ex_waddr",    ex_waddr,    16'h0);
        chk("rst_ex_wen",      ex_wen,      16'h0);
        chk("rst_ex_memread",  ex_memread,  16'h0);
        chk("rst_ex_memwrite", ex_memwrite, 16'h0);
        chk("rst_if_ready",    if_ready,    16'h1);
        chk("rst_halted",      halted,      16'h0);

        // ADD r3,r1,r2
        offer(16'h0312, 16'h0010);
        chk("add_raddr1", raddr1, 16'h1);
        chk("add_raddr2", raddr2, 16'h2);
        step();
        chk("add_ex_valid", ex_valid, 16'h1);
        chk("add_ex_pc",    ex_pc,    16'h0010);
        chk("add_ex_op1",   ex_op1,   16'h0005);
        chk("add_ex_op2",   ex_op2,   16'h0001);
        chk("add_ex_waddr", ex_waddr, 16'h3);
        chk("add_ex_wen",   ex_wen,   16'h1);
        chk("add_ex_aluop", ex_aluop, 16'h0);

        // LW r4,r1,-1 then ADD r5,r4,r2 : load-use on source 1
        offer(16'h841F, 16'h0020);
        offer(16'h0542, 16'h0022);
        chk("lw_ex_memread", ex_memread, 16'h1);
        chk("lw_ex_op2",     ex_op2,     16'hFFFF);
        chk("lw_ex_waddr",   ex_waddr,   16'h4);
        chk("lu1_if_ready",  if_ready,   16'h0);
        chk("lu1_raddr1",    raddr1,     16'h4);
        step();
        chk("lu1_bubble_valid", ex_valid, 16'h0);
        chk("lu1_bubble_wen",   ex_wen,   16'h0);
        chk("lu1_bubble_mr",    ex_memread, 16'h0);
        chk("lu1_if_ready_after", if_ready, 16'h1);
        step();
        chk("lu1_add_valid", ex_valid, 16'h1);
        chk("lu1_add_pc",    ex_pc,    16'h0022);
        chk("lu1_add_waddr", ex_waddr, 16'h5);
        chk("lu1_add_op1",   ex_op1,   16'h0040);
        chk("lu1_add_op2",   ex_op2,   16'h0001);

        // LW r4 then ADD r5,r2,r4 : load-use on source 2
        offer(16'h841F, 16'h0030);
        offer(16'h0524, 16'h0032);
        chk("lu2_if_ready", if_ready, 16'h0);
        chk("lu2_raddr2",   raddr2,   16'h4);
        step();
        chk("lu2_bubble_valid", ex_valid, 16'h0);
        step();
        chk("lu2_add_valid", ex_valid, 16'h1);
        chk("lu2_add_op1",   ex_op1,   16'h0001);
        chk("lu2_add_op2",   ex_op2,   16'h0040);

        // LW r6 then LLB r6,0x80 : no sources, no stall
        offer(16'h861F, 16'h0040);
        offer(16'hB680, 16'h0042);
        chk("llb_if_ready", if_ready, 16'h1);
        step();
        chk("llb_ex_valid", ex_valid, 16'h1);
        chk("llb_ex_pc",    ex_pc,    16'h0042);
        chk("llb_ex_op1",   ex_op1,   16'h0000);
        chk("llb_ex_op2",   ex_op2,   16'hFF80);
        chk("llb_ex_wen",   ex_wen,   16'h1);
        chk("llb_ex_waddr", ex_waddr, 16'h6);

        // SW r2,r1,3
        rf[1] = 16'h000A;
        rf[2] = 16'h004D;
        offer(16'h9213, 16'h0050);
        chk("sw_raddr1", raddr1, 16'h1);
        chk("sw_raddr2", raddr2, 16'h2);
        step();
        chk("sw_ex_op1",      ex_op1,      16'h000A);
        chk("sw_ex_op2",      ex_op2,      16'h0003);
        chk("sw_ex_sdata",    ex_sdata,    16'h004D);
        chk("sw_ex_memwrite", ex_memwrite, 16'h1);
        chk("sw_ex_wen",      ex_wen,      16'h0);
        chk("sw_ex_memread",  ex_memread,  16'h0);

        // Shift op 5: r3 = r1 by 7
        offer(16'h5317, 16'h0054);
        step();
        chk("shf_ex_op1",   ex_op1,   16'h000A);
        chk("shf_ex_op2",   ex_op2,   16'h0007);
        chk("shf_ex_aluop", ex_aluop, 16'h5);
        chk("shf_ex_waddr", ex_waddr, 16'h3);

        // LHB r7,0xAB
        offer(16'hA7AB, 16'h0058);
        chk("lhb_raddr1", raddr1, 16'h7);
        step();
        chk("lhb_ex_op1", ex_op1, 16'h1234);
        chk("lhb_ex_op2", ex_op2, 16'h00AB);
        chk("lhb_ex_wen", ex_wen, 16'h1);

        // Reserved op 12: valid bubble carrying the PC
        offer(16'hC123, 16'h0070);
        step();
        chk("rsv_ex_valid", ex_valid, 16'h1);
        chk("rsv_ex_pc",    ex_pc,    16'h0070);
        chk("rsv_ex_wen",   ex_wen,   16'h0);
        chk("rsv_ex_mw",    ex_memwrite, 16'h0);

        // Flush during a load-use stall
        rf[1] = 16'h0005;
        rf[2] = 16'h0001;
        offer(16'h841F, 16'h0060);
        offer(16'h0542, 16'h0062);
        chk("fl_pre_if_ready", if_ready, 16'h0);
        flush = 1'b1;
        #1;
        chk("fl_if_ready_during", if_ready, 16'h0);
        step();
        flush = 1'b0;
        chk("fl_ex_valid",   ex_valid,        16'h0);
        chk("fl_id_valid",   dut.id_valid_q,  16'h0);
        chk("fl_ex_memread", ex_memread,      16'h0);
        chk("fl_if_ready",   if_ready,        16'h1);
        step();
        chk("fl_ex_valid_next", ex_valid, 16'h0);

        // Reset in the middle of a stall
        offer(16'h841F, 16'h0064);
        offer(16'h0542, 16'h0066);
        chk("rs_pre_if_ready", if_ready, 16'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rs_if_ready", if_ready, 16'h1);
        chk("rs_ex_valid", ex_valid, 16'h0);

`ifdef HALT_DECODE_EN
        // HALT freezes the stage until reset
        offer(16'hF000, 16'h0080);
        offer(16'h0312, 16'h0082);
        chk("halt_halted",   halted,   16'h1);
        chk("halt_if_ready", if_ready, 16'h0);
        chk("halt_ex_valid", ex_valid, 16'h0);
        chk("halt_ex_wen",   ex_wen,   16'h0);
        if_valid = 1'b1;
        if_instr = 16'h0312;
        if_pc    = 16'h0084;
        step();
        step();
        chk("halt_hold_ex_valid", ex_valid, 16'h0);
        chk("halt_hold_if_ready", if_ready, 16'h0);
        if_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush = 1'b0;
        chk("halt_flush_halted",   halted,   16'h1);
        chk("halt_flush_if_ready", if_ready, 16'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("halt_rst_halted",   halted,   16'h0);
        chk("halt_rst_if_ready", if_ready, 16'h1);
`else
        // Without the feature, op 15 is a reserved bubble and fetch continues
        offer(16'hF000, 16'h0080);
        chk("op15_if_ready_id", if_ready, 16'h1);
        step();
        chk("op15_ex_valid", ex_valid, 16'h1);
        chk("op15_ex_pc",    ex_pc,    16'h0080);
        chk("op15_ex_wen",   ex_wen,   16'h0);
        chk("op15_halted",   halted,   16'h0);
        chk("op15_if_ready", if_ready, 16'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the 16-bit pipelined processor.
- Holds the IF/ID register and decodes the held instruction.
- Drives register-file read addresses combinationally and samples the returned operands. The register file provides same-cycle write-through.
- Loads the ID/EX pipeline register, detects load-use hazards (stall + bubble) and honours branch flushes from EX.

Parameters:
DSIZE, 16, datapath and instruction width
ASIZE, 4, register address width (16 registers)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
if_valid  in  1  fetch offers an instruction
if_instr  in  DSIZE  instruction word
if_pc  in  DSIZE  PC of offered instruction
if_ready  out  1  stage accepts offered instruction this cycle
flush  in  1  discard ID and EX contents (branch taken)
raddr1  out  ASIZE  register-file read address 1
raddr2  out  ASIZE  register-file read address 2
rdata1  in  DSIZE  read data 1
rdata2  in  DSIZE  read data 2
ex_valid  out  1  ID/EX holds a real instruction
ex_pc  out  DSIZE  PC of instruction
ex_aluop  out  4  opcode passed to ALU (instr[15:12])
ex_op1  out  DSIZE  ALU operand 1
ex_op2  out  DSIZE  ALU operand 2
ex_sdata  out  DSIZE  store data
ex_waddr  out  ASIZE  destination register
ex_wen  out  1  writeback enable
ex_memread  out  1  load
ex_memwrite  out  1  store
halted  out  1  HALT decoded (optional feature)

Behaviour:
- Field layout: op=instr[15:12], rd=[11:8], rs=[7:4], rt=[3:0].
- IF/ID register: id_valid, id_instr, id_pc.
  - Loads when if_ready; id_valid takes if_valid.
  - if_ready = !stall.
- Decode (combinational, from IF/ID):
  - op 0-3 (ADD/SUB/AND/OR): raddr1=rs, raddr2=rt, op1=rdata1, op2=rdata2, wen=1, waddr=rd.
  - op 4-7 (shifts): raddr1=rs, op1=rdata1, op2=zero-extended rt (imm4), wen=1. Source 2 unused.
  - op 8 LW: raddr1=rs, op1=rdata1, op2=sign-extended imm4, memread=1, wen=1, waddr=rd.
  - op 9 SW: raddr1=rs, raddr2=rd, op1=rdata1, op2=sign-extended imm4, sdata=rdata2, memwrite=1, wen=0.
  - op 10 LHB: raddr1=rd, op1=rdata1, op2=zero-extended instr[7:0], wen=1, waddr=rd.
  - op 11 LLB: op2=sign-extended instr[7:0], op1=0, wen=1, waddr=rd. No sources.
  - op 12-14: reserved. Issue as bubble (all controls 0, ex_valid=1 carries PC).
  - op 15: see optional feature.
- Unused raddr outputs drive 0 (address value is don't-care to the register file).
- Load-use stall = id_valid & ex_valid & ex_memread & (use1 & raddr1==ex_waddr | use2 & raddr2==ex_waddr).
  - While stall: IF/ID holds; ID/EX loads a bubble (ex_valid=0, wen/memread/memwrite=0, data fields 0).
  - A stall lasts exactly 1 cycle, since the bubble clears ex_memread.
- Normal edge: ID/EX loads decoded values, ex_valid=id_valid. Control bits are gated by id_valid.
- Latency: instruction accepted at edge N appears on ex_* after edge N+1.
- flush at edge: IF/ID and ID/EX both become bubbles, regardless of stall; if_ready is still !stall.
- Priority: rst > flush > stall > normal.
- Reset: id_valid=0, id_instr=0, id_pc=0, all ex_* = 0, halted=0.
  - Reset mid-stall clears the stall next cycle.

Optional Feature:
- Macro HALT_DECODE_EN.
- Defined:
  - op 15 in a valid ID slot sets sticky halted=1 at the edge and issues a bubble.
  - Thereafter if_ready=0 and only bubbles issue.
  - flush does not clear halted; only rst does.
- Undefined: op 15 is decoded as a reserved bubble, halted is tied 0, and fetch continues.

Test Plan:
- rst held 2 cycles, then released with if_valid=0 -> all ex_* = 0, if_ready=1, halted=0.
- ADD r3,r1,r2 (0x0312) with rdata1=5, rdata2=1 -> raddr1=1, raddr2=2; next edge ex_op1=5, ex_op2=1, ex_waddr=3, ex_wen=1, ex_aluop=0.
- LW r4,r1,-1 (0x841F) followed by ADD r5,r4,r2 (0x0542) -> one cycle with if_ready=0 and an ex bubble. The ADD then issues with raddr1=4. With the sources swapped (0x0524, raddr2=4), the same stall occurs.
- LLB r6,0x80 (0xB680) -> ex_op2=0xFF80, ex_wen=1, no stall even if the preceding op was LW to r6.
- SW r2,r1,3 (0x9213) with rdata1=10, rdata2=77 -> ex_op2=3, ex_sdata=77, ex_memwrite=1, ex_wen=0.
- flush asserted during a load-use stall -> next cycle ex_valid=0, id_valid=0. With HALT_DECODE_EN, 0xF000 -> halted=1 and if_ready stays 0 until rst.
